// File: rtl/scr1_pipe_wbu.sv
// Writeback unit: merges EXU and LSU results onto the MPRF write port.
// Optional macro SCR1_WBU_FWD_EN enables operand forwarding from WBU.
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif
`ifndef SCR1_MPRF_AWIDTH
`define SCR1_MPRF_AWIDTH 5
`endif

module scr1_pipe_wbu #(
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         exu2wbu_alu_req_i,
  input  logic [`SCR1_MPRF_AWIDTH-1:0] exu2wbu_alu_rd_addr_i,
  input  logic [`SCR1_XLEN-1:0]        exu2wbu_alu_rd_data_i,
  input  logic                         exu2wbu_ld_issue_i,
  input  logic [`SCR1_MPRF_AWIDTH-1:0] exu2wbu_ld_rd_addr_i,
  output logic                         wbu2exu_ld_rdy_o,
  input  logic                         lsu2wbu_ld_rsp_i,
  input  logic                         lsu2wbu_ld_rsp_err_i,
  input  logic [`SCR1_XLEN-1:0]        lsu2wbu_ld_data_i,
  input  logic [`SCR1_MPRF_AWIDTH-1:0] exu2wbu_rs1_addr_i,
  input  logic [`SCR1_MPRF_AWIDTH-1:0] exu2wbu_rs2_addr_i,
  output logic                         wbu2exu_stall_o,
  output logic                         wbu2exu_rs1_fwd_o,
  output logic                         wbu2exu_rs2_fwd_o,
  output logic [`SCR1_XLEN-1:0]        wbu2exu_rs1_fwd_data_o,
  output logic [`SCR1_XLEN-1:0]        wbu2exu_rs2_fwd_data_o,
  output logic                         wbu2mprf_w_req_o,
  output logic [`SCR1_MPRF_AWIDTH-1:0] wbu2mprf_rd_addr_o,
  output logic [`SCR1_XLEN-1:0]        wbu2mprf_rd_data_o
);

  localparam int AW = `SCR1_MPRF_AWIDTH;
  localparam int XW = `SCR1_XLEN;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic          ld_pend;
  logic [AW-1:0] ld_rd;
  logic [AW-1:0] buf_rd   [BUF_DEPTH];
  logic [XW-1:0] buf_data [BUF_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          rsp_wr;
  logic          buf_empty;
  logic          buf_full;
  logic          pop;
  logic          push;
  logic          direct;
  logic          alu_acc;
  logic          ld_haz;
  logic          rs1_nz;
  logic          rs2_nz;
  logic          raw_ld;
  logic          waw_ld;
  logic          full_stall;
  logic          stall;
  logic          ld_rdy;
  logic          rs1_buf_hit;
  logic          rs2_buf_hit;
  logic [PW-1:0] lk_idx;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [XW-1:0] w_data;
`ifdef SCR1_WBU_FWD_EN
  logic [XW-1:0] rs1_buf_data;
  logic [XW-1:0] rs2_buf_data;
  logic          rs1_wp_hit;
  logic          rs2_wp_hit;
`else
  logic          wb_stall;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign rsp_wr = lsu2wbu_ld_rsp_i & ld_pend & ~lsu2wbu_ld_rsp_err_i
                & (ld_rd != '0);
  assign buf_empty = (count == '0);
  assign buf_full  = (count == CW'(BUF_DEPTH));
  assign pop       = ~buf_empty & ~rsp_wr;
  assign ld_rdy    = ~ld_pend | lsu2wbu_ld_rsp_i;

  assign ld_haz = ld_pend & (ld_rd != '0) & ~lsu2wbu_ld_rsp_i;
  assign rs1_nz = (exu2wbu_rs1_addr_i != '0);
  assign rs2_nz = (exu2wbu_rs2_addr_i != '0);

  assign raw_ld = ld_haz
                & ((rs1_nz & (exu2wbu_rs1_addr_i == ld_rd))
                 | (rs2_nz & (exu2wbu_rs2_addr_i == ld_rd)));
  assign waw_ld = ld_haz & exu2wbu_alu_req_i
                & (exu2wbu_alu_rd_addr_i == ld_rd);
  assign full_stall = exu2wbu_alu_req_i & buf_full & ~pop;

  // Scan buffered entries oldest to youngest; the last match wins
  always_comb begin
    rs1_buf_hit = 1'b0;
    rs2_buf_hit = 1'b0;
`ifdef SCR1_WBU_FWD_EN
    rs1_buf_data = '0;
    rs2_buf_data = '0;
`endif
    lk_idx = head;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      if (CW'(k) < count) begin
        if (buf_rd[lk_idx] == exu2wbu_rs1_addr_i) begin
          rs1_buf_hit = 1'b1;
`ifdef SCR1_WBU_FWD_EN
          rs1_buf_data = buf_data[lk_idx];
`endif
        end
        if (buf_rd[lk_idx] == exu2wbu_rs2_addr_i) begin
          rs2_buf_hit = 1'b1;
`ifdef SCR1_WBU_FWD_EN
          rs2_buf_data = buf_data[lk_idx];
`endif
        end
      end
      lk_idx = ptr_inc(lk_idx);
    end
  end

  // Direct ALU writes are excluded: that path depends on stall itself.
`ifdef SCR1_WBU_FWD_EN
  assign stall = raw_ld | waw_ld | full_stall;
`else
  assign wb_stall =
      (rs1_nz & (rs1_buf_hit
               | (rsp_wr & (exu2wbu_rs1_addr_i == ld_rd))))
    | (rs2_nz & (rs2_buf_hit
               | (rsp_wr & (exu2wbu_rs2_addr_i == ld_rd))));
  assign stall = raw_ld | waw_ld | full_stall | wb_stall;
`endif

  assign alu_acc = exu2wbu_alu_req_i & ~stall
                 & (exu2wbu_alu_rd_addr_i != '0);
  assign direct  = alu_acc & buf_empty & ~rsp_wr;
  assign push    = alu_acc & ~direct;

  // Write-port arbitration: load response, then FIFO head, then ALU
  always_comb begin
    w_req  = 1'b0;
    w_addr = '0;
    w_data = '0;
    if (rsp_wr) begin
      w_req  = 1'b1;
      w_addr = ld_rd;
      w_data = lsu2wbu_ld_data_i;
    end else if (pop) begin
      w_req  = 1'b1;
      w_addr = buf_rd[head];
      w_data = buf_data[head];
    end else if (direct) begin
      w_req  = 1'b1;
      w_addr = exu2wbu_alu_rd_addr_i;
      w_data = exu2wbu_alu_rd_data_i;
    end
  end

`ifdef SCR1_WBU_FWD_EN
  assign rs1_wp_hit = w_req & (w_addr == exu2wbu_rs1_addr_i);
  assign rs2_wp_hit = w_req & (w_addr == exu2wbu_rs2_addr_i);
  assign wbu2exu_rs1_fwd_o = rs1_nz & (rs1_wp_hit | rs1_buf_hit);
  assign wbu2exu_rs2_fwd_o = rs2_nz & (rs2_wp_hit | rs2_buf_hit);
  assign wbu2exu_rs1_fwd_data_o = ~rs1_nz    ? '0
                                : rs1_wp_hit ? w_data
                                : rs1_buf_hit ? rs1_buf_data : '0;
  assign wbu2exu_rs2_fwd_data_o = ~rs2_nz    ? '0
                                : rs2_wp_hit ? w_data
                                : rs2_buf_hit ? rs2_buf_data : '0;
`else
  assign wbu2exu_rs1_fwd_o      = 1'b0;
  assign wbu2exu_rs2_fwd_o      = 1'b0;
  assign wbu2exu_rs1_fwd_data_o = '0;
  assign wbu2exu_rs2_fwd_data_o = '0;
`endif

  assign wbu2exu_stall_o    = stall;
  assign wbu2exu_ld_rdy_o   = ld_rdy;
  assign wbu2mprf_w_req_o   = w_req;
  assign wbu2mprf_rd_addr_o = w_addr;
  assign wbu2mprf_rd_data_o = w_data;

  // Track the single outstanding load destination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_pend <= 1'b0;
      ld_rd   <= '0;
    end else begin
      if (lsu2wbu_ld_rsp_i) ld_pend <= 1'b0;
      if (exu2wbu_ld_issue_i & ld_rdy) begin
        ld_pend <= 1'b1;
        ld_rd   <= exu2wbu_ld_rd_addr_i;
      end
    end
  end

  // ALU write buffer, strictly oldest-first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_rd[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      if (push) begin
        buf_rd[tail]   <= exu2wbu_alu_rd_addr_i;
        buf_data[tail] <= exu2wbu_alu_rd_data_i;
        tail           <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_scr1_pipe_wbu.sv
// Testbench for scr1_pipe_wbu: directed plan steps then random traffic.
// Expected values come from a queue-based reference model.
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif
`ifndef SCR1_MPRF_AWIDTH
`define SCR1_MPRF_AWIDTH 5
`endif

module tb_scr1_pipe_wbu;

  localparam int D = 2;

  logic        clk;
  logic        rst_n;
  logic        alu_req;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_addr;
  logic        ld_rdy;
  logic        rsp;
  logic        err;
  logic [31:0] ld_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        fwd1;
  logic        fwd2;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic        w_req;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  scr1_pipe_wbu #(.BUF_DEPTH(D)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .exu2wbu_alu_req_i      (alu_req),
    .exu2wbu_alu_rd_addr_i  (alu_rd),
    .exu2wbu_alu_rd_data_i  (alu_data),
    .exu2wbu_ld_issue_i     (ld_issue),
    .exu2wbu_ld_rd_addr_i   (ld_addr),
    .wbu2exu_ld_rdy_o       (ld_rdy),
    .lsu2wbu_ld_rsp_i       (rsp),
    .lsu2wbu_ld_rsp_err_i   (err),
    .lsu2wbu_ld_data_i      (ld_data),
    .exu2wbu_rs1_addr_i     (rs1),
    .exu2wbu_rs2_addr_i     (rs2),
    .wbu2exu_stall_o        (stall),
    .wbu2exu_rs1_fwd_o      (fwd1),
    .wbu2exu_rs2_fwd_o      (fwd2),
    .wbu2exu_rs1_fwd_data_o (fwd1_data),
    .wbu2exu_rs2_fwd_data_o (fwd2_data),
    .wbu2mprf_w_req_o       (w_req),
    .wbu2mprf_rd_addr_o     (w_addr),
    .wbu2mprf_rd_data_o     (w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          m_pend;
  logic [4:0]  m_ldrd;
  int          tests;
  int          fails;

`ifdef SCR1_WBU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_req  = 0; alu_rd  = 0; alu_data = 0;
    ld_issue = 0; ld_addr = 0;
    rsp      = 0; err     = 0; ld_data  = 0;
    rs1      = 0; rs2     = 0;
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = 0;
    m_ldrd = 0;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_wreq"},  w_req,  0);
    chk({tag, "_waddr"}, w_addr, 0);
    chk({tag, "_wdata"}, w_data, 0);
    chk({tag, "_stall"}, stall,  0);
    chk({tag, "_ldrdy"}, ld_rdy, 1);
    chk({tag, "_fwd"},   {fwd1, fwd2, fwd1_data, fwd2_data}, 0);
  endtask

  function automatic bit rs_hit(input logic [4:0] a);
    return (rs1 != 0 && rs1 == a) || (rs2 != 0 && rs2 == a);
  endfunction

  // One clock: compare DUT to the model at negedge, then advance model
  task automatic cycle(input bit dchk = 0, input logic dreq = 0,
                       input logic [4:0] da = 0,
                       input logic [31:0] dd = 0,
                       input logic ds = 0);
    bit          rsp_w, pop, ldh, st, acc, ereq, erdy;
    bit          ef1, ef2;
    logic [4:0]  ea;
    logic [31:0] ed, efd1, efd2;
    int          n;
    @(negedge clk);
    n     = q.size();
    rsp_w = rsp && !err && m_pend && m_ldrd != 0;
    pop   = n > 0 && !rsp_w;
    ldh   = m_pend && m_ldrd != 0 && !rsp;
    st    = 0;
    if (ldh && rs_hit(m_ldrd)) st = 1;
    if (ldh && alu_req && alu_rd == m_ldrd) st = 1;
    if (alu_req && n == D && !pop) st = 1;
    if (!FWD) begin
      foreach (q[i]) if (rs_hit(q[i].rd)) st = 1;
      if (rsp_w && rs_hit(m_ldrd)) st = 1;
    end
    acc  = alu_req && !st && alu_rd != 0;
    ereq = 0; ea = 0; ed = 0;
    if (rsp_w) begin
      ereq = 1; ea = m_ldrd; ed = ld_data;
    end else if (pop) begin
      ereq = 1; ea = q[0].rd; ed = q[0].data;
    end else if (acc) begin
      ereq = 1; ea = alu_rd; ed = alu_data;
    end
    erdy = !m_pend || rsp;
    ef1 = 0; ef2 = 0; efd1 = 0; efd2 = 0;
    if (FWD) begin
      foreach (q[i]) begin
        if (rs1 != 0 && q[i].rd == rs1) begin ef1 = 1; efd1 = q[i].data; end
        if (rs2 != 0 && q[i].rd == rs2) begin ef2 = 1; efd2 = q[i].data; end
      end
      if (ereq && rs1 != 0 && ea == rs1) begin ef1 = 1; efd1 = ed; end
      if (ereq && rs2 != 0 && ea == rs2) begin ef2 = 1; efd2 = ed; end
    end
    chk("m_wreq",  w_req,  ereq);
    chk("m_waddr", w_addr, ea);
    chk("m_wdata", w_data, ed);
    chk("m_stall", stall,  st);
    chk("m_ldrdy", ld_rdy, erdy);
    chk("m_fwd1",  {fwd1, fwd1_data}, {ef1, efd1});
    chk("m_fwd2",  {fwd2, fwd2_data}, {ef2, efd2});
    if (dchk) begin
      chk("d_wreq",  w_req, dreq);
      if (dreq) chk("d_wport", {w_addr, w_data}, {da, dd});
      chk("d_stall", stall, ds);
    end
    if (pop) void'(q.pop_front());
    if (acc && !(n == 0 && !rsp_w)) q.push_back('{alu_rd, alu_data});
    if (rsp) m_pend = 0;
    if (ld_issue && erdy) begin m_pend = 1; m_ldrd = ld_addr; end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_chk("rst");
    rst_n = 1;

    // direct ALU write
    alu_req = 1; alu_rd = 5; alu_data = 32'h1234;
    cycle(1, 1, 5, 32'h1234, 0);
    idle();

    // load response collides with ALU request
    ld_issue = 1; ld_addr = 7;
    cycle();
    idle();
    rsp = 1; ld_data = 32'hAAAA;
    alu_req = 1; alu_rd = 3; alu_data = 32'h55;
    cycle(1, 1, 7, 32'hAAAA, 0);
    idle();
    cycle(1, 1, 3, 32'h55, 0);

    // load RAW, WAW, then error response
    ld_issue = 1; ld_addr = 9;
    cycle();
    idle();
    rs1 = 9;
    cycle(1, 0, 0, 0, 1);
    alu_req = 1; alu_rd = 9; alu_data = 32'h1;
    cycle(1, 0, 0, 0, 1);
    alu_req = 0;
    rsp = 1; err = 1; ld_data = 32'hDEAD;
    cycle(1, 0, 0, 0, 0);
    idle();

    // FIFO full while load responses hold the port
    ld_issue = 1; ld_addr = 10;
    cycle();
    rsp = 1; ld_data = 32'h110; ld_addr = 11;
    alu_req = 1; alu_rd = 12; alu_data = 32'hC12;
    cycle(1, 1, 10, 32'h110, 0);
    ld_data = 32'h111; ld_addr = 13;
    alu_rd = 14; alu_data = 32'hC14;
    cycle(1, 1, 11, 32'h111, 0);
    ld_data = 32'h113; ld_addr = 15;
    alu_rd = 16; alu_data = 32'hC16;
    cycle(1, 1, 13, 32'h113, 1);
    ld_issue = 0; ld_data = 32'h115;
    cycle(1, 1, 15, 32'h115, 1);
    rsp = 0;
    cycle(1, 1, 12, 32'hC12, 0);
    idle();
    cycle(1, 1, 14, 32'hC14, 0);
    cycle(1, 1, 16, 32'hC16, 0);

    // operand matching a buffered entry
    ld_issue = 1; ld_addr = 20;
    cycle();
    idle();
    rsp = 1; ld_data = 32'h2020;
    alu_req = 1; alu_rd = 4; alu_data = 32'hBEEF;
    cycle(1, 1, 20, 32'h2020, 0);
    idle();
    rs2 = 4;
    cycle(1, 1, 4, 32'hBEEF, !FWD);
    idle();

    // x0 destination is dropped
    alu_req = 1; alu_rd = 0; alu_data = 32'hFF;
    cycle(1, 0, 0, 0, 0);
    idle();
    cycle(1, 0, 0, 0, 0);

    // reset with two buffered entries and a pending load
    ld_issue = 1; ld_addr = 21;
    cycle();
    rsp = 1; ld_data = 32'h21; ld_addr = 22;
    alu_req = 1; alu_rd = 3; alu_data = 32'h33;
    cycle();
    ld_data = 32'h22; ld_addr = 23;
    alu_rd = 4; alu_data = 32'h44;
    cycle(1, 1, 22, 32'h22, 0);
    idle();
    rst_n = 0;
    #1;
    reset_chk("mid_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      alu_req  = ($urandom % 2) == 0;
      alu_rd   = 5'($urandom % 8);
      alu_data = $urandom;
      ld_issue = ($urandom % 3) == 0;
      ld_addr  = 5'($urandom % 8);
      rsp      = m_pend && (($urandom % 2) == 0);
      err      = ($urandom % 8) == 0;
      ld_data  = $urandom;
      rs1      = 5'($urandom % 8);
      rs2      = 5'($urandom % 8);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
